// File: rtl/crash_course_cpu_mem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and the
// crash_course_cpu_mem_arbiter. Port 0 is the CPU, port 1 the loader/debug
// port. The master modport is the environment side (requesters plus memory).
// The slave modport is the arbiter side.
interface crash_course_cpu_mem_arbiter_if;
    logic       p0_req;
    logic       p0_we;
    logic [7:0] p0_addr;
    logic [7:0] p0_wdata;
    logic       p0_gnt;
    logic       p0_rvalid;
    logic [7:0] p0_rdata;

    logic       p1_req;
    logic       p1_we;
    logic [7:0] p1_addr;
    logic [7:0] p1_wdata;
    logic       p1_gnt;
    logic       p1_rvalid;
    logic [7:0] p1_rdata;

    logic [7:0] mem_address;
    logic       mem_store_enable;
    logic [7:0] mem_store_data;
    logic [7:0] mem_load_data;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_address, mem_store_enable, mem_store_data,
        output mem_load_data
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_address, mem_store_enable, mem_store_data,
        input  mem_load_data
    );
endinterface

// File: rtl/crash_course_cpu_mem_arbiter.sv
// Two-port data-memory arbiter. The CPU (port 0) has priority. The loader
// port (port 1) is guaranteed a slot after MAX_HOLD consecutive CPU grants
// during which it was waiting. Loads return registered data one enabled
// cycle after the grant.
// Optional feature: define CC_MEM_ARB_CONFLICT_COUNT_EN to build a
// saturating 16-bit contention counter. Without the macro, conflict_count
// reads as zero.
module crash_course_cpu_mem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                              clk,
    input  logic                              async_rst_n,
    input  logic                              clk_en,
    input  logic                              system_enabled,
    crash_course_cpu_mem_arbiter_if.slave     bus,
    output logic [15:0]                       conflict_count
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       p0_rvalid_q, p0_rvalid_d;
    logic       p1_rvalid_q, p1_rvalid_d;
    logic [7:0] p0_rdata_q, p0_rdata_d;
    logic [7:0] p1_rdata_q, p1_rdata_d;

    logic grantAllowed;
    logic bothReq;
    logic gnt0;
    logic gnt1;
    logic [3:0] holdBase;

    assign grantAllowed = clk_en && system_enabled;
    assign bothReq      = bus.p0_req && bus.p1_req;

    // Combinational grant: CPU first, loader when it is alone or its wait limit is reached
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (grantAllowed) begin
            if (bothReq) begin
                if (hold_q == MaxHold) gnt1 = 1'b1;
                else                   gnt0 = 1'b1;
            end else if (bus.p0_req) begin
                gnt0 = 1'b1;
            end else if (bus.p1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign bus.p0_gnt           = gnt0;
    assign bus.p1_gnt           = gnt1;
    assign bus.mem_address      = gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign bus.mem_store_data   = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign bus.mem_store_enable = async_rst_n && ((gnt0 && bus.p0_we) || (gnt1 && bus.p1_we));
    assign bus.p0_rvalid        = p0_rvalid_q;
    assign bus.p1_rvalid        = p1_rvalid_q;
    assign bus.p0_rdata         = p0_rdata_q;
    assign bus.p1_rdata         = p1_rdata_q;

    // Next-state: ownership, CPU-streak counter and registered load returns
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        p0_rvalid_d = p0_rvalid_q;
        p1_rvalid_d = p1_rvalid_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        holdBase    = (state_q == OWN1) ? 4'd0 : hold_q;
        if (clk_en) begin
            if (!system_enabled) begin
                state_d     = IDLE;
                hold_d      = 4'd0;
                p0_rvalid_d = 1'b0;
                p1_rvalid_d = 1'b0;
            end else begin
                if (gnt0)      state_d = OWN0;
                else if (gnt1) state_d = OWN1;
                else           state_d = IDLE;

                if (gnt1 || !bus.p1_req) hold_d = 4'd0;
                else if (gnt0)           hold_d = (holdBase == MaxHold) ? holdBase : holdBase + 4'd1;
                else                     hold_d = holdBase;

                p0_rvalid_d = gnt0 && !bus.p0_we;
                p1_rvalid_d = gnt1 && !bus.p1_we;
                if (gnt0 && !bus.p0_we) p0_rdata_d = bus.mem_load_data;
                if (gnt1 && !bus.p1_we) p1_rdata_d = bus.mem_load_data;
            end
        end
    end

    // State registers, frozen while clk_en is low
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= 8'h00;
            p1_rdata_q  <= 8'h00;
        end else if (clk_en) begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

`ifdef CC_MEM_ARB_CONFLICT_COUNT_EN
    logic [15:0] conflict_q, conflict_d;

    // Count enabled cycles in which both ports competed for a grant
    always_comb begin
        conflict_d = conflict_q;
        if (grantAllowed && bothReq && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
    end

    // Contention counter register
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)  conflict_q <= 16'h0000;
        else if (clk_en)   conflict_q <= conflict_d;
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_crash_course_cpu_mem_arbiter.sv
// Self-checking bench for crash_course_cpu_mem_arbiter: directed scenarios
// with literal expectations, then randomized traffic. A behavioural model
// compares the outputs every cycle.
module tb_crash_course_cpu_mem_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef CC_MEM_ARB_CONFLICT_COUNT_EN
    localparam bit ConfEn = 1'b1;
`else
    localparam bit ConfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic        system_enabled;
    logic [15:0] conflict_count;

    crash_course_cpu_mem_arbiter_if bus();

    crash_course_cpu_mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk            (clk),
        .async_rst_n    (async_rst_n),
        .clk_en         (clk_en),
        .system_enabled (system_enabled),
        .bus            (bus.slave),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Environment data memory, written by the arbiter's store strobe
    logic [7:0] mem [256];
    logic       memReady = 1'b0;

    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
            memReady <= 1'b1;
        end else if (async_rst_n && bus.mem_store_enable) begin
            mem[bus.mem_address] <= bus.mem_store_data;
        end
    end

    assign bus.mem_load_data = mem[bus.mem_address];

    // Grant seen in the cycle that just closed, used by the random requesters
    logic sawGnt0 = 1'b0;
    logic sawGnt1 = 1'b0;
    always @(negedge clk) begin
        sawGnt0 <= bus.p0_gnt;
        sawGnt1 <= bus.p1_gnt;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: streak of CPU wins while the loader waits, pending read returns, own memory image
    int         streak;
    int         expConf;
    logic       expRv0, expRv1;
    logic [7:0] expRd0, expRd1;
    logic [7:0] modelMem [256];

    initial begin
        logic       allowed, e0, e1, eWe, eStore;
        logic [7:0] eAddr, eData;
        for (int i = 0; i < 256; i++) modelMem[i] = 8'(i * 37 + 11);
        streak = 0; expConf = 0;
        expRv0 = 1'b0; expRv1 = 1'b0; expRd0 = 8'h00; expRd1 = 8'h00;
        forever begin
            @(negedge clk);
            if (!async_rst_n) begin
                streak = 0; expConf = 0;
                expRv0 = 1'b0; expRv1 = 1'b0; expRd0 = 8'h00; expRd1 = 8'h00;
            end
            allowed = clk_en && system_enabled;
            e0      = allowed && bus.p0_req && !(bus.p1_req && streak >= MAX_HOLD);
            e1      = allowed && bus.p1_req && !e0;
            eAddr   = e1 ? bus.p1_addr  : bus.p0_addr;
            eData   = e1 ? bus.p1_wdata : bus.p0_wdata;
            eWe     = e1 ? bus.p1_we    : bus.p0_we;
            eStore  = async_rst_n && (e0 || e1) && eWe;

            checkOutput("p0_gnt",      16'(bus.p0_gnt),           16'(e0));
            checkOutput("p1_gnt",      16'(bus.p1_gnt),           16'(e1));
            checkOutput("mem_address", 16'(bus.mem_address),      16'(eAddr));
            checkOutput("mem_wdata",   16'(bus.mem_store_data),   16'(eData));
            checkOutput("mem_we",      16'(bus.mem_store_enable), 16'(eStore));
            checkOutput("p0_rvalid",   16'(bus.p0_rvalid),        16'(expRv0));
            checkOutput("p1_rvalid",   16'(bus.p1_rvalid),        16'(expRv1));
            checkOutput("p0_rdata",    16'(bus.p0_rdata),         16'(expRd0));
            checkOutput("p1_rdata",    16'(bus.p1_rdata),         16'(expRd1));
            checkOutput("conflicts",   conflict_count,            ConfEn ? 16'(expConf) : 16'h0000);

            if (clk_en) begin
                if (allowed && bus.p0_req && bus.p1_req && expConf < 65535) expConf = expConf + 1;
                if (!system_enabled || !bus.p1_req || e1) streak = 0;
                else if (e0 && streak < MAX_HOLD)         streak = streak + 1;
                expRv0 = e0 && !bus.p0_we;
                expRv1 = e1 && !bus.p1_we;
                if (expRv0) expRd0 = modelMem[bus.p0_addr];
                if (expRv1) expRd1 = modelMem[bus.p1_addr];
                if (eStore) modelMem[eAddr] = eData;
            end
        end
    end

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        logic [9:0] holdPattern;
        logic [4:0] restartPattern;
        int         k;
        holdPattern    = 10'b1000010000;
        restartPattern = 5'b10000;

        async_rst_n = 1'b0; clk_en = 1'b0; system_enabled = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #12 async_rst_n = 1'b1;
        nextCycle();
        clk_en = 1'b1; system_enabled = 1'b1;

        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
        #1 checkOutput("preload p1_gnt", 16'(bus.p1_gnt), 16'h1);
        nextCycle();

        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("load p0_gnt", 16'(bus.p0_gnt), 16'h1);
        checkOutput("load addr",   16'(bus.mem_address), 16'h0010);
        checkOutput("load no we",  16'(bus.mem_store_enable), 16'h0);
        nextCycle();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #1;
        checkOutput("load rvalid", 16'(bus.p0_rvalid), 16'h1);
        checkOutput("load rdata",  16'(bus.p0_rdata), 16'h00A5);
        nextCycle();
        #1;
        checkOutput("rvalid drop", 16'(bus.p0_rvalid), 16'h0);
        checkOutput("rdata hold",  16'(bus.p0_rdata), 16'h00A5);

        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h03, 8'h5A);
        #1;
        checkOutput("store p1_gnt", 16'(bus.p1_gnt), 16'h1);
        checkOutput("store we",     16'(bus.mem_store_enable), 16'h1);
        checkOutput("store addr",   16'(bus.mem_address), 16'h0003);
        checkOutput("store data",   16'(bus.mem_store_data), 16'h005A);
        nextCycle();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #1 checkOutput("store no rvalid", 16'(bus.p1_rvalid), 16'h0);
        nextCycle();

        applyStimulus(1, 1, 8'h20, 8'h11, 1, 1, 8'h30, 8'h22);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("hold seq p1", 16'(bus.p1_gnt), 16'(holdPattern[i]));
            checkOutput("hold seq p0", 16'(bus.p0_gnt), 16'(!holdPattern[i]));
            nextCycle();
        end
        checkOutput("conflict ten", conflict_count, ConfEn ? 16'd10 : 16'd0);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        nextCycle();

        applyStimulus(1, 1, 8'h21, 8'h33, 1, 1, 8'h31, 8'h44);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            clk_en = (i % 2 == 0);
            #1;
            if (clk_en) begin
                checkOutput("gated seq p1", 16'(bus.p1_gnt), 16'(holdPattern[k]));
                checkOutput("gated seq p0", 16'(bus.p0_gnt), 16'(!holdPattern[k]));
                k++;
            end else begin
                checkOutput("gated off gnt", 16'({bus.p0_gnt, bus.p1_gnt}), 16'h0);
            end
            nextCycle();
        end
        clk_en = 1'b1;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        nextCycle();

        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        nextCycle();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #1 checkOutput("pre-reset rvalid", 16'(bus.p0_rvalid), 16'h1);
        #1 async_rst_n = 1'b0;
        #1;
        checkOutput("reset rvalid", 16'(bus.p0_rvalid), 16'h0);
        checkOutput("reset rdata",  16'(bus.p0_rdata), 16'h0000);
        checkOutput("reset count",  conflict_count, 16'h0000);
        #3 async_rst_n = 1'b1;
        nextCycle();
        #1 checkOutput("post-reset rvalid", 16'(bus.p0_rvalid), 16'h0);
        nextCycle();

        applyStimulus(1, 1, 8'h22, 8'h55, 1, 1, 8'h32, 8'h66);
        nextCycle();
        nextCycle();
        system_enabled = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("disabled gnt", 16'({bus.p0_gnt, bus.p1_gnt}), 16'h0);
            checkOutput("disabled we",  16'(bus.mem_store_enable), 16'h0);
            nextCycle();
        end
        system_enabled = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("restart p1", 16'(bus.p1_gnt), 16'(restartPattern[i]));
            checkOutput("restart p0", 16'(bus.p0_gnt), 16'(!restartPattern[i]));
            nextCycle();
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        nextCycle();

        for (int c = 0; c < 3000; c++) begin
            nextCycle();
            if (!bus.p0_req || sawGnt0) begin
                bus.p0_req   = ($urandom_range(0, 99) < 60);
                bus.p0_we    = 1'($urandom_range(0, 1));
                bus.p0_addr  = 8'($urandom_range(0, 15));
                bus.p0_wdata = 8'($urandom_range(0, 255));
            end
            if (!bus.p1_req || sawGnt1) begin
                bus.p1_req   = ($urandom_range(0, 99) < 60);
                bus.p1_we    = 1'($urandom_range(0, 1));
                bus.p1_addr  = 8'($urandom_range(0, 15));
                bus.p1_wdata = 8'($urandom_range(0, 255));
            end
            clk_en         = ($urandom_range(0, 99) < 80);
            system_enabled = ($urandom_range(0, 99) < 92);
        end

        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        clk_en = 1'b1; system_enabled = 1'b1;
        nextCycle();
        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
